// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the I/D main-memory port arbiter.
// State and requester-id constants used by the FSM and its round-robin helper.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;

   // Wide enough for MEM_LAT-1 with MEM_LAT up to 15.
   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin winner select between the I-cache and D-cache requests.
// On a tie, the requester that was not granted last time wins.
module rr_arbiter2
   import mem_port_arbiter_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
   input  logic last_grant,
   output logic gnt_vld,
   output logic gnt_id
);

   always_comb begin
      gnt_vld = i_req | d_req;
      gnt_id  = REQ_I;
      if (i_req && d_req) begin
         gnt_id = ~last_grant;
      end else if (d_req) begin
         gnt_id = REQ_D;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency main-memory port between the I-cache miss path and the
// D-cache path: one access at a time, MEM_LAT cycles on the bus, then a ready pulse.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ready,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_q, last_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

   logic gnt_vld, gnt_id;

   rr_arbiter2 u_rr (
      .i_req      (i_req),
      .d_req      (d_req),
      .last_grant (last_q),
      .gnt_vld    (gnt_vld),
      .gnt_id     (gnt_id)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_vld) begin
               owner_d = gnt_id;
               addr_d  = (gnt_id == REQ_D) ? d_addr : i_addr;
               we_d    = (gnt_id == REQ_D) && d_we;
               wdata_d = (gnt_id == REQ_D) ? d_wdata : '0;
               cnt_d   = CNT_W'(MEM_LAT - 1);
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            // Memory data is only valid in the final access cycle.
            if (cnt_q == '0) begin
               state_d = ST_DONE;
               if (!we_q) begin
                  if (owner_q == REQ_D) d_rdata_d = mem_rdata;
                  else                  i_rdata_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            last_d  = owner_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         owner_q   <= REQ_I;
         last_q    <= REQ_I;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   // The bus only ever reflects latched values, so live inputs cannot tear an access.
   assign mem_en    = (state_q == ST_ACCESS);
   assign mem_we    = mem_en && we_q;
   assign mem_addr  = mem_en ? addr_q : '0;
   assign mem_wdata = mem_en ? wdata_q : '0;
   assign i_ready   = (state_q == ST_DONE) && (owner_q == REQ_I);
   assign d_ready   = (state_q == ST_DONE) && (owner_q == REQ_D);
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter (MEM_LAT=3) plus a small
// back-to-back check on a MEM_LAT=1 instance.
module tb_mem_port_arbiter;

   localparam int LAT = 3;
   localparam int NS  = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        i_req, i_ready, d_req, d_we, d_ready, mem_en, mem_we, busy;
   logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   logic        s_req, s_ready, s_dreq, s_dwe, s_dready, s_mem_en, s_mem_we, s_busy;
   logic [31:0] s_addr, s_rdata, s_daddr, s_dwdata, s_drdata, s_mem_addr, s_mem_wdata, s_mem_rdata;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
      .clk(clk), .rst(rst),
      .i_req(s_req), .i_addr(s_addr), .i_ready(s_ready), .i_rdata(s_rdata),
      .d_req(s_dreq), .d_we(s_dwe), .d_addr(s_daddr), .d_wdata(s_dwdata),
      .d_ready(s_dready), .d_rdata(s_drdata),
      .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .mem_rdata(s_mem_rdata), .busy(s_busy)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] hash(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   typedef struct { logic id; logic we; logic [31:0] addr; logic [31:0] wdata; int start; } bus_t;
   typedef struct { logic id; logic we; logic [31:0] rdata; int cyc; } rsp_t;
   typedef struct { logic [31:0] addr; int en; int rdy; } s_t;

   bus_t bus_q[$];
   rsp_t rsp_q[$];
   s_t   s_q[$];

   // Requester and reference-model state, index 0 = I-cache, 1 = D-cache.
   bit          active[2], granted[2], withdraw[2], allow[2], rq[2];
   int          gap[2], grant_cyc[2], done_cyc[2];
   logic [31:0] r_addr[2], r_wdata[2];
   logic        r_we[2];
   logic        model_last;
   int          free_at, busy_from;
   logic [31:0] exp_rd[2];
   int          s_seen = 0;

   task automatic model_reset();
      bus_q.delete();
      rsp_q.delete();
      free_at    = 0;
      busy_from  = 0;
      model_last = 1'b0;
      for (int r = 0; r < 2; r++) begin
         active[r] = 0; granted[r] = 0; withdraw[r] = 0; rq[r] = 0;
         gap[r] = 0; grant_cyc[r] = -10; done_cyc[r] = -10;
         exp_rd[r] = '0;
      end
      i_req = 1'b0;
      d_req = 1'b0;
   endtask

   // One cycle of requester behaviour plus the reference arbitration decision.
   task automatic drive_cycle();
      logic w;
      for (int r = 0; r < 2; r++) begin
         if (active[r] && cyc == done_cyc[r] + 1) begin
            active[r] = 0; rq[r] = 0; gap[r] = $urandom_range(0, 4);
         end
         if (!active[r] && allow[r]) begin
            if (gap[r] == 0) begin
               active[r] = 1; granted[r] = 0; rq[r] = 1;
               r_addr[r] = $urandom; r_wdata[r] = $urandom;
               r_we[r] = (r == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
               withdraw[r] = ($urandom_range(0, 3) == 0);
            end else begin
               gap[r]--;
            end
         end
         if (!active[r]) begin
            r_addr[r] = $urandom; r_wdata[r] = $urandom; r_we[r] = 1'($urandom_range(0, 1));
         end
         if (active[r] && granted[r] && withdraw[r] && cyc >= grant_cyc[r] + 2) begin
            rq[r] = 0; r_addr[r] = $urandom; r_wdata[r] = $urandom; r_we[r] = ~r_we[r];
         end
      end
      if (cyc >= free_at && (rq[0] || rq[1])) begin
         w = (rq[0] && rq[1]) ? !model_last : rq[1];
         model_last   = w;
         granted[w]   = 1;
         grant_cyc[w] = cyc;
         done_cyc[w]  = cyc + LAT + 1;
         free_at      = cyc + LAT + 2;
         busy_from    = cyc + 1;
         bus_q.push_back('{w, w ? r_we[1] : 1'b0, r_addr[w], r_wdata[w], cyc + 1});
         rsp_q.push_back('{w, w ? r_we[1] : 1'b0, hash(r_addr[w]), cyc + LAT + 1});
      end
      i_req   = rq[0];
      i_addr  = r_addr[0];
      d_req   = rq[1];
      d_we    = r_we[1];
      d_addr  = r_addr[1];
      d_wdata = r_wdata[1];
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive_cycle();
   endtask

   // Memory: returns valid data only in the final cycle of an access.
   initial begin
      int mrun = 0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         mrun = mem_en ? mrun + 1 : 0;
         mem_rdata = (mem_en && mrun == LAT) ? hash(mem_addr) : $urandom;
      end
   end

   initial begin
      s_mem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         s_mem_rdata = s_mem_en ? hash(s_mem_addr) : $urandom;
      end
   end

   // Monitor for the MEM_LAT=3 instance.
   initial begin
      bus_t cb;
      rsp_t e;
      int brun = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            brun = 0;
            continue;
         end
         if (mem_en) begin
            if (brun == 0) begin
               chk("bus_pending", 64'(bus_q.size() > 0), 1);
               if (bus_q.size() > 0) begin
                  cb = bus_q.pop_front();
                  chk("bus_start", cyc, cb.start);
               end
            end
            brun++;
            chk("mem_addr", mem_addr, cb.addr);
            chk("mem_we", mem_we, cb.we);
            if (cb.we) chk("mem_wdata", mem_wdata, cb.wdata);
         end else if (brun != 0) begin
            chk("mem_en_len", brun, LAT);
            brun = 0;
         end
         chk("busy", busy, 64'(cyc >= busy_from && cyc < free_at));
         if (i_ready || d_ready) begin
            chk("ready_onehot", 64'(i_ready && d_ready), 0);
            chk("rsp_pending", 64'(rsp_q.size() > 0), 1);
            if (rsp_q.size() > 0) begin
               e = rsp_q.pop_front();
               chk("ready_id", d_ready, e.id);
               chk("ready_cyc", cyc, e.cyc);
               if (!e.we) exp_rd[e.id] = e.rdata;
            end
         end else if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
            e = rsp_q.pop_front();
            chk("ready_missing", {i_ready, d_ready}, e.id ? 2'b01 : 2'b10);
         end
         chk("i_rdata", i_rdata, exp_rd[0]);
         chk("d_rdata", d_rdata, exp_rd[1]);
      end
   end

   // Monitor for the MEM_LAT=1 instance.
   initial begin
      s_t   e;
      logic prev_en = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_en = 1'b0;
            continue;
         end
         if (s_mem_en) begin
            chk("s_en_single", prev_en, 0);
            chk("s_pending", 64'(s_q.size() > 0), 1);
            if (s_q.size() > 0) begin
               chk("s_en_cyc", cyc, s_q[0].en);
               chk("s_mem_addr", s_mem_addr, s_q[0].addr);
            end
         end
         if (s_ready) begin
            chk("s_rsp_pending", 64'(s_q.size() > 0), 1);
            if (s_q.size() > 0) begin
               e = s_q.pop_front();
               chk("s_ready_cyc", cyc, e.rdy);
               chk("s_rdata", s_rdata, hash(e.addr));
               s_seen++;
            end
         end
         prev_en = s_mem_en;
      end
   end

   // Back-to-back I reads on the MEM_LAT=1 instance: a new address every 3 cycles.
   initial begin
      s_req = 0; s_addr = '0; s_dreq = 0; s_dwe = 0; s_daddr = '0; s_dwdata = '0;
      wait (rst === 1'b1);
      @(posedge clk);
      #1;
      for (int k = 0; k < NS; k++) begin
         s_addr = $urandom;
         s_req  = 1'b1;
         s_q.push_back('{s_addr, cyc + 1, cyc + 2});
         repeat (3) @(posedge clk);
         #1;
      end
      s_req = 1'b0;
   end

   initial begin
      rst = 1'b0;
      i_addr = '0; d_we = 0; d_addr = '0; d_wdata = '0;
      r_addr[0] = '0; r_addr[1] = '0; r_wdata[0] = '0; r_wdata[1] = '0; r_we[0] = 0; r_we[1] = 0;
      allow[0] = 0; allow[1] = 0;
      model_reset();
      #12;
      chk("rst_i_ready", i_ready, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk);
      #3 rst = 1'b1;

      // Both request in the first cycle: D must win the first tie.
      allow[0] = 1; allow[1] = 1;
      repeat (400) step();

      allow[0] = 0; allow[1] = 0;
      repeat (3 * LAT + 10) step();

      // Reset asserted in the second ACCESS cycle of an I read.
      allow[0] = 1; gap[0] = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (granted[0] && cyc == grant_cyc[0] + 2) break;
      end
      chk("rst_mid_reached", 64'(granted[0] && cyc == grant_cyc[0] + 2), 1);
      chk("pre_rst_mem_en", mem_en, 1);
      #1 rst = 1'b0;
      #1;
      chk("midrst_mem_en", mem_en, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_i_ready", i_ready, 0);
      chk("midrst_d_ready", d_ready, 0);
      model_reset();
      allow[0] = 1; allow[1] = 0;
      @(posedge clk);
      #3 rst = 1'b1;
      repeat (30) step();

      allow[0] = 0;
      repeat (3 * LAT + 10) step();
      chk("rsp_drained", rsp_q.size(), 0);
      chk("bus_drained", bus_q.size(), 0);
      chk("s_served", s_seen, NS);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache miss path (read-only) and the data-cache path (read refill and write-through).
- Sits between the two cache controllers and main memory.
- Accepts one access at a time, drives memory for a fixed MEM_LAT-cycle access, and returns data with a one-cycle ready pulse.
- Round-robin arbitration prevents starvation when both caches stall at once.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 3, cycles memory needs per access (legal range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (rst=0 resets).
- i_req  in  1  I-cache request; held until i_ready.
- i_addr  in  ADDR_W  I-cache read address.
- i_ready  out  1  one-cycle completion pulse to I-cache.
- i_rdata  out  DATA_W  read data, valid when i_ready=1.
- d_req  in  1  D-cache request; held until d_ready.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  D-cache address.
- d_wdata  in  DATA_W  D-cache write data.
- d_ready  out  1  one-cycle completion pulse to D-cache.
- d_rdata  out  DATA_W  read data, valid when d_ready=1 and the access was a read.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid in the last access cycle.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, last_grant=I, counter=0.
  - All outputs 0, including rdata registers.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Any req: pick winner, latch winner id, addr, we and wdata (we=0 for I), load counter=MEM_LAT-1, go ACCESS.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: the requester not granted last wins. After reset, D wins the first tie.
- ACCESS:
  - mem_en=1; mem_we/mem_addr/mem_wdata driven from the latched values only, never from live inputs.
  - counter decrements each cycle.
  - counter==0 is the final access cycle: capture mem_rdata into the owner's rdata register (reads only), go DONE.
- DONE:
  - mem_en=0.
  - Owner's ready=1 for exactly one cycle; the other ready stays 0.
  - last_grant <= owner; go IDLE.
- Latency:
  - req first high in cycle t with the arbiter idle → ready in cycle t+MEM_LAT+1.
  - mem_en high for exactly MEM_LAT cycles, t+1..t+MEM_LAT.
  - Minimum spacing between grants is MEM_LAT+2 cycles.
- Requester rule: deassert req (registered) at the clock edge ending the ready cycle. The IDLE cycle after DONE sees the deasserted req.
- rdata registers hold their value until the next read completion for that requester. A D-cache write leaves d_rdata unchanged.
- Request withdrawn during ACCESS: the access completes anyway and ready still pulses. A write is therefore never torn.
- Inputs changing during ACCESS have no effect.
- Losing requester: waits with req held and ready=0 for any number of cycles, and is granted in the next IDLE.
- Reset asserted mid-ACCESS: immediate return to IDLE, mem_en=0, no ready pulse. The memory write may be partial; caches are reset with the same signal.
- MEM_LAT=1: ACCESS lasts one cycle.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
  - Requester ids: REQ_I=1'b0, REQ_D=1'b1.
- One sub-module, rr_arbiter2:
  - Combinational 2-way round-robin winner select from i_req, d_req and last_grant.
  - Output is the grant id plus a valid flag.
  - The FSM, counter and latches stay in mem_port_arbiter.

Test Plan:
- Single I read, MEM_LAT=3:
  - Stimulus: i_req high at cycle 2, i_addr=0x40, mem_rdata=0xDEADBEEF in the last access cycle.
  - Required: mem_en high in cycles 3-5 with mem_addr=0x40 and mem_we=0; i_ready high only in cycle 6; i_rdata=0xDEADBEEF.
- D write:
  - Stimulus: d_req=1, d_we=1, d_addr=0x80, d_wdata=0x12345678.
  - Required: mem_we=1 for 3 cycles, mem_wdata=0x12345678, d_ready pulses once, d_rdata unchanged.
- Tie after reset:
  - Stimulus: both req high in the same cycle.
  - Required: D served first, then I, with i_ready exactly 5 cycles after d_ready. Assert both again: D is served after I (alternation).
- Withdrawal:
  - Stimulus: d_req dropped in the second ACCESS cycle while its address toggles.
  - Required: mem_addr stays at the latched value for all 3 cycles; d_ready still pulses in the DONE cycle.
- Reset mid-ACCESS:
  - Stimulus: rst=0 asynchronously in the second ACCESS cycle.
  - Required: mem_en, busy and both readys are 0 immediately. After release with i_req high, a fresh access starts with latency MEM_LAT+1.
- MEM_LAT=1 build:
  - Stimulus: back-to-back I reads.
  - Required: i_ready every 3 cycles; mem_en one cycle per access.
